// File: rtl/regfile_arbiter.sv
// Two-requester arbiter in front of a 1-write/2-read register file with one-cycle read latency.
// Optional feature macro: RF_ARB_BYPASS_EN forwards a same-cycle granted write into the read response.
module regfile_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_write,
    input  logic [1:0]  req0_wadr,
    input  logic [15:0] req0_wdata,
    input  logic [1:0]  req0_radr1,
    input  logic [1:0]  req0_radr2,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_write,
    input  logic [1:0]  req1_wadr,
    input  logic [15:0] req1_wdata,
    input  logic [1:0]  req1_radr1,
    input  logic [1:0]  req1_radr2,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [15:0] rsp_data1,
    output logic [15:0] rsp_data2,
    output logic        rf_write_en,
    output logic        rf_read_en,
    output logic [1:0]  rf_write_adr,
    output logic [1:0]  rf_read_adr1,
    output logic [1:0]  rf_read_adr2,
    output logic [15:0] rf_write_data,
    input  logic [15:0] rf_read_data1,
    input  logic [15:0] rf_read_data2
);

    logic prio_q, prio_d;
    logic pend_q, pend_d;
    logic pend_id_q, pend_id_d;
    logic conflict;
    logic gnt0, gnt1;
    logic wr_gnt, wr_id, rd_gnt, rd_id;

    // Grants are combinational; gating with reset keeps both ready outputs low while in reset.
    always_comb begin
        conflict = req0_valid && req1_valid && (req0_write == req1_write);
        gnt0     = reset && req0_valid && !(conflict && prio_q);
        gnt1     = reset && req1_valid && !(conflict && !prio_q);
        wr_gnt   = (gnt0 && req0_write) || (gnt1 && req1_write);
        wr_id    = gnt1 && req1_write;
        rd_gnt   = (gnt0 && !req0_write) || (gnt1 && !req1_write);
        rd_id    = gnt1 && !req1_write;
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // NOTE: every output gets a default first, so no path through this block can infer a latch.
    always_comb begin
        rf_write_en   = 1'b0;
        rf_write_adr  = 2'd0;
        rf_write_data = 16'd0;
        rf_read_en    = 1'b0;
        rf_read_adr1  = 2'd0;
        rf_read_adr2  = 2'd0;
        if (wr_gnt) begin
            rf_write_en   = 1'b1;
            rf_write_adr  = wr_id ? req1_wadr  : req0_wadr;
            rf_write_data = wr_id ? req1_wdata : req0_wdata;
        end
        if (rd_gnt) begin
            rf_read_en   = 1'b1;
            rf_read_adr1 = rd_id ? req1_radr1 : req0_radr1;
            rf_read_adr2 = rd_id ? req1_radr2 : req0_radr2;
        end
    end

    // The pointer moves only when a same-operation conflict was resolved this cycle.
    always_comb begin
        prio_d    = conflict ? !prio_q : prio_q;
        pend_d    = rd_gnt;
        pend_id_d = rd_id;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q    <= 1'b0;
            pend_q    <= 1'b0;
            pend_id_q <= 1'b0;
        end else begin
            prio_q    <= prio_d;
            pend_q    <= pend_d;
            pend_id_q <= pend_id_d;
        end
    end

    assign rsp0_valid = pend_q && !pend_id_q;
    assign rsp1_valid = pend_q && pend_id_q;

`ifdef RF_ARB_BYPASS_EN
    logic        byp1_q, byp2_q;
    logic [15:0] byp_data_q;

    // Remember, per read port, whether the read collided with a write granted in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byp1_q     <= 1'b0;
            byp2_q     <= 1'b0;
            byp_data_q <= 16'd0;
        end else begin
            byp1_q     <= rd_gnt && wr_gnt && (rf_read_adr1 == rf_write_adr);
            byp2_q     <= rd_gnt && wr_gnt && (rf_read_adr2 == rf_write_adr);
            byp_data_q <= rf_write_data;
        end
    end

    assign rsp_data1 = !pend_q ? 16'd0 : (byp1_q ? byp_data_q : rf_read_data1);
    assign rsp_data2 = !pend_q ? 16'd0 : (byp2_q ? byp_data_q : rf_read_data2);
`else
    assign rsp_data1 = pend_q ? rf_read_data1 : 16'd0;
    assign rsp_data2 = pend_q ? rf_read_data2 : 16'd0;
`endif

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: behavioural model compared every cycle, directed
// scenarios with literal expectations, then randomized traffic with occasional reset pulses.
`timescale 1ns/1ps
module tb_regfile_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_write, req1_valid, req1_write;
    logic [1:0]  req0_wadr, req0_radr1, req0_radr2, req1_wadr, req1_radr1, req1_radr2;
    logic [15:0] req0_wdata, req1_wdata;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [15:0] rsp_data1, rsp_data2;
    logic        rf_write_en, rf_read_en;
    logic [1:0]  rf_write_adr, rf_read_adr1, rf_read_adr2;
    logic [15:0] rf_write_data;
    logic [15:0] rf_read_data1 = 16'd0;
    logic [15:0] rf_read_data2 = 16'd0;

    always #5 clk = ~clk;

    regfile_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_wadr(req0_wadr), .req0_wdata(req0_wdata), .req0_radr1(req0_radr1), .req0_radr2(req0_radr2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_wadr(req1_wadr), .req1_wdata(req1_wdata), .req1_radr1(req1_radr1), .req1_radr2(req1_radr2),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
        .rf_write_en(rf_write_en), .rf_read_en(rf_read_en), .rf_write_adr(rf_write_adr),
        .rf_read_adr1(rf_read_adr1), .rf_read_adr2(rf_read_adr2), .rf_write_data(rf_write_data),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2)
    );

    // Register file stand-in: read-before-write, garbage on the data bus when not reading.
    logic [15:0] rf_regs [4] = '{default: 16'd0};
    always @(posedge clk) begin
        if (rf_read_en) begin
            rf_read_data1 <= rf_regs[rf_read_adr1];
            rf_read_data2 <= rf_regs[rf_read_adr2];
        end else begin
            rf_read_data1 <= 16'($urandom);
            rf_read_data2 <= 16'($urandom);
        end
        if (rf_write_en) rf_regs[rf_write_adr] <= rf_write_data;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: architectural registers, fairness pointer, and the response owed next cycle.
    logic [15:0] m_regs [4] = '{default: 16'd0};
    bit          m_ptr = 1'b0;
    bit          m_rsp_v = 1'b0, m_rsp_id = 1'b0;
    logic [15:0] m_d1 = 16'd0, m_d2 = 16'd0;
    bit          m_g0 = 1'b0, m_g1 = 1'b0;
    bit          e_conf, e_g0, e_g1, e_wr, e_rd;
    logic [1:0]  e_wa, e_r1, e_r2;
    logic [15:0] e_wd;

    always @(negedge clk) begin
        if (!reset) begin
            check("reset_ready", {req1_ready, req0_ready}, 64'd0);
            check("reset_rf", {rf_write_en, rf_read_en, rf_write_adr, rf_read_adr1, rf_read_adr2, rf_write_data}, 64'd0);
            check("reset_rsp", {rsp1_valid, rsp0_valid, rsp_data1, rsp_data2}, 64'd0);
            m_ptr = 1'b0; m_rsp_v = 1'b0; m_g0 = 1'b0; m_g1 = 1'b0;
        end else begin
            e_conf = req0_valid && req1_valid && (req0_write == req1_write);
            e_g0 = req0_valid && !(e_conf && m_ptr == 1'b1);
            e_g1 = req1_valid && !(e_conf && m_ptr == 1'b0);
            e_wr = 1'b0; e_rd = 1'b0; e_wa = 2'd0; e_wd = 16'd0; e_r1 = 2'd0; e_r2 = 2'd0;
            if (e_g0 && req0_write)  begin e_wr = 1'b1; e_wa = req0_wadr; e_wd = req0_wdata; end
            if (e_g1 && req1_write)  begin e_wr = 1'b1; e_wa = req1_wadr; e_wd = req1_wdata; end
            if (e_g0 && !req0_write) begin e_rd = 1'b1; e_r1 = req0_radr1; e_r2 = req0_radr2; end
            if (e_g1 && !req1_write) begin e_rd = 1'b1; e_r1 = req1_radr1; e_r2 = req1_radr2; end
            check("ready", {req1_ready, req0_ready}, {62'd0, e_g1, e_g0});
            check("rf_write", {rf_write_en, rf_write_adr, rf_write_data}, {45'd0, e_wr, e_wa, e_wd});
            check("rf_read", {rf_read_en, rf_read_adr1, rf_read_adr2}, {59'd0, e_rd, e_r1, e_r2});
            check("rsp", {rsp1_valid, rsp0_valid, rsp_data1, rsp_data2},
                  {30'd0, m_rsp_v && m_rsp_id, m_rsp_v && !m_rsp_id,
                   m_rsp_v ? m_d1 : 16'd0, m_rsp_v ? m_d2 : 16'd0});
            m_rsp_v = e_rd;
            m_rsp_id = e_g1 && !req1_write;
            m_d1 = m_regs[e_r1];
            m_d2 = m_regs[e_r2];
`ifdef RF_ARB_BYPASS_EN
            if (e_wr && e_rd && e_r1 == e_wa) m_d1 = e_wd;
            if (e_wr && e_rd && e_r2 == e_wa) m_d2 = e_wd;
`endif
            if (e_wr) m_regs[e_wa] = e_wd;
            if (e_conf) m_ptr = !m_ptr;
            m_g0 = e_g0; m_g1 = e_g1;
        end
    end

    task automatic set_req(input int n, input bit v, input bit w, input logic [1:0] wa,
                           input logic [15:0] wd, input logic [1:0] r1, input logic [1:0] r2);
        if (n == 0) begin
            req0_valid = v; req0_write = w; req0_wadr = wa; req0_wdata = wd; req0_radr1 = r1; req0_radr2 = r2;
        end else begin
            req1_valid = v; req1_write = w; req1_wadr = wa; req1_wdata = wd; req1_radr1 = r1; req1_radr2 = r2;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic mid_cycle();
        @(negedge clk); #1;
    endtask

    task automatic rand_req(input int n);
        set_req(n, $urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom), 16'($urandom),
                2'($urandom), 2'($urandom));
    endtask

    initial begin
        reset = 1'b0;
        set_req(0, 1'b1, 1'b0, 2'd0, 16'd0, 2'd0, 2'd1);
        set_req(1, 1'b1, 1'b0, 2'd0, 16'd0, 2'd2, 2'd3);
        mid_cycle();
        check("lit_reset_ready", {req1_ready, req0_ready}, 64'd0);
        check("lit_reset_rden", {63'd0, rf_read_en}, 64'd0);
        next_cycle();

        // Both requesters read continuously from reset: grants and responses alternate.
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                set_req(0, 1'b0, 1'b0, 2'd0, 16'd0, 2'd0, 2'd0);
                set_req(1, 1'b0, 1'b0, 2'd0, 16'd0, 2'd0, 2'd0);
            end
            mid_cycle();
            if (i < 4) check("lit_alt_gnt", {req1_ready, req0_ready}, (i % 2 == 1) ? 64'd2 : 64'd1);
            check("lit_alt_rsp", {rsp1_valid, rsp0_valid}, (i == 0) ? 64'd0 : ((i % 2 == 1) ? 64'd1 : 64'd2));
            next_cycle();
        end

        // Write 0xBEEF to reg 2, read it back from requester 1 the next cycle.
        set_req(0, 1'b1, 1'b1, 2'd2, 16'hBEEF, 2'd0, 2'd0);
        next_cycle();
        set_req(0, 1'b0, 1'b0, 2'd0, 16'd0, 2'd0, 2'd0);
        set_req(1, 1'b1, 1'b0, 2'd0, 16'd0, 2'd2, 2'd0);
        next_cycle();
        set_req(1, 1'b0, 1'b0, 2'd0, 16'd0, 2'd0, 2'd0);
        mid_cycle();
        check("lit_raw_rsp", {rsp1_valid, rsp0_valid, rsp_data1}, {46'd0, 2'b10, 16'hBEEF});
        next_cycle();

        // Same-cycle write and read of reg 1, reg 3 read unaffected.
        set_req(0, 1'b1, 1'b1, 2'd1, 16'h0005, 2'd0, 2'd0);
        next_cycle();
        set_req(0, 1'b1, 1'b1, 2'd3, 16'h00AA, 2'd0, 2'd0);
        next_cycle();
        set_req(0, 1'b1, 1'b1, 2'd1, 16'h1234, 2'd0, 2'd0);
        set_req(1, 1'b1, 1'b0, 2'd0, 16'd0, 2'd1, 2'd3);
        mid_cycle();
        check("lit_mixed_gnt", {req1_ready, req0_ready}, 64'd3);
        next_cycle();
        set_req(0, 1'b0, 1'b0, 2'd0, 16'd0, 2'd0, 2'd0);
        set_req(1, 1'b0, 1'b0, 2'd0, 16'd0, 2'd0, 2'd0);
        mid_cycle();
        check("lit_mixed_valid", {rsp1_valid, rsp0_valid}, 64'd2);
`ifdef RF_ARB_BYPASS_EN
        check("lit_mixed_d1", {48'd0, rsp_data1}, 64'h1234);
`else
        check("lit_mixed_d1", {48'd0, rsp_data1}, 64'h0005);
`endif
        check("lit_mixed_d2", {48'd0, rsp_data2}, 64'h00AA);
        next_cycle();

        // Read conflict with pointer at 0: requester 1 waits one cycle with its fields held.
        set_req(0, 1'b1, 1'b0, 2'd0, 16'd0, 2'd0, 2'd0);
        set_req(1, 1'b1, 1'b0, 2'd0, 16'd0, 2'd3, 2'd2);
        mid_cycle();
        check("lit_hold_gnt", {req1_ready, req0_ready}, 64'd1);
        next_cycle();
        set_req(0, 1'b0, 1'b0, 2'd0, 16'd0, 2'd0, 2'd0);
        mid_cycle();
        check("lit_hold_regnt", {req1_ready, req0_ready, rf_read_adr1, rf_read_adr2}, {58'd0, 2'b10, 2'd3, 2'd2});
        next_cycle();
        set_req(1, 1'b0, 1'b0, 2'd0, 16'd0, 2'd0, 2'd0);

        // Pointer now 1; reset pulsed with a read pending drops it and clears the pointer.
        set_req(0, 1'b1, 1'b0, 2'd0, 16'd0, 2'd1, 2'd1);
        mid_cycle();
        check("lit_pre_rst_gnt", {req1_ready, req0_ready}, 64'd1);
        next_cycle();
        reset = 1'b0;
        set_req(0, 1'b0, 1'b0, 2'd0, 16'd0, 2'd0, 2'd0);
        mid_cycle();
        check("lit_mid_rst_out", {rsp1_valid, rsp0_valid, rsp_data1, rsp_data2, rf_read_en, rf_write_en}, 64'd0);
        next_cycle();
        reset = 1'b1;
        set_req(0, 1'b1, 1'b0, 2'd0, 16'd0, 2'd0, 2'd0);
        set_req(1, 1'b1, 1'b0, 2'd0, 16'd0, 2'd1, 2'd1);
        mid_cycle();
        check("lit_post_rst_rsp", {rsp1_valid, rsp0_valid}, 64'd0);
        check("lit_post_rst_ptr", {req1_ready, req0_ready}, 64'd1);
        next_cycle();

        // Randomized traffic; a requester holds its fields while valid and not granted.
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 63) != 0);
            if (!(req0_valid && !m_g0)) rand_req(0);
            if (!(req1_valid && !m_g1)) rand_req(1);
            next_cycle();
        end

        reset = 1'b1;
        set_req(0, 1'b0, 1'b0, 2'd0, 16'd0, 2'd0, 2'd0);
        set_req(1, 1'b0, 1'b0, 2'd0, 16'd0, 2'd0, 2'd0);
        next_cycle();
        mid_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset; low resets all state immediately, regardless of clk.
REQ-003 The block SHALL have ports req0_valid / req1_valid, input, 1 bit each: request present from requester 0 (execute) / 1 (load writeback).
REQ-004 The block SHALL have ports req0_ready / req1_ready, output, 1 bit each: request accepted this cycle (combinational grant).
REQ-005 The block SHALL have ports reqN_write, input, 1 bit: 1 = write, 0 = read.
REQ-006 The block SHALL have ports reqN_wadr [1:0], reqN_wdata [15:0], reqN_radr1 [1:0], reqN_radr2 [1:0], input: write address/data, read addresses.
REQ-007 The block SHALL have ports rsp0_valid / rsp1_valid, output, 1 bit each: read response for requester 0 / 1.
REQ-008 The block SHALL have ports rsp_data1 / rsp_data2, output, 16 bits each: shared read response data.
REQ-009 The block SHALL have ports rf_write_en, rf_read_en (1 bit), rf_write_adr, rf_read_adr1, rf_read_adr2 (2 bits), rf_write_data (16 bits), output: register file port drive.
REQ-010 The block SHALL have ports rf_read_data1 / rf_read_data2, input, 16 bits each: register file read data, valid the cycle after rf_read_en.

Function
REQ-011 A request SHALL transfer in cycle N when valid and ready are both high; requesters hold all request fields stable while valid and not ready.
REQ-012 Single valid request SHALL be granted in the same cycle.
REQ-013 Both valid with different operations SHALL both be granted in the same cycle (write on write port, read on read port).
REQ-014 Both valid with the same operation SHALL grant only the requester named by a 1-bit priority pointer; the pointer SHALL then flip to the other requester.
REQ-015 The priority pointer SHALL change only on a same-operation conflict grant.
REQ-016 A granted write SHALL drive rf_write_en=1, rf_write_adr, and rf_write_data combinationally in cycle N.
REQ-017 A granted read SHALL drive rf_read_en=1, rf_read_adr1, and rf_read_adr2 combinationally in cycle N.
REQ-018 With no grant, all rf_* outputs SHALL be 0.
REQ-019 A read granted in cycle N SHALL assert the granted requester's rspN_valid for exactly one cycle, N+1, with rsp_data1/2 = rf_read_data1/2.
REQ-020 At most one rspN_valid SHALL be high per cycle; responses have no backpressure.
REQ-021 When no rspN_valid is high, rsp_data1/2 SHALL be 0.
REQ-022 Read-latency tracking SHALL use a registered pending flag plus a 1-bit requester id.
REQ-023 A new read granted in N+1 SHALL be independent of the read response delivered in N+1 (back-to-back reads at full rate).
REQ-024 A write in cycle N followed by a read of the same address in N+1 or later SHALL return the written value.

Reset
REQ-025 While reset is low, the following SHALL hold: req0_ready=req1_ready=0; rsp0_valid=rsp1_valid=0; rsp_data1/2=0; all rf_* outputs 0; priority pointer=0; pending flag=0.
REQ-026 Reset asserted with a read pending SHALL discard the pending read; no response issues after reset deasserts.
REQ-027 The first grant is possible in the first rising edge cycle with reset high.

Configuration
REQ-028 Macro RF_ARB_BYPASS_EN SHALL select same-cycle write-read forwarding.
REQ-029 With RF_ARB_BYPASS_EN defined, a read and write granted in the same cycle N with matching addresses SHALL return the written value in N+1. This applies independently per read address: rf_read_adr1 == rf_write_adr gives rsp_data1 = that write data; rf_read_adr2 == rf_write_adr gives rsp_data2 = that write data.
REQ-030 Without RF_ARB_BYPASS_EN, such a read SHALL return the pre-write register value.

Verification
REQ-031 The bench SHALL cover: reset low mid-read (read granted, reset pulsed before N+1) -> no rspN_valid; all outputs 0; pointer 0.
REQ-032 The bench SHALL cover: req0 write adr 2 data 0xBEEF in cycle N, req1 read radr1=2 in cycle N+1 -> rsp1_valid in N+2, rsp_data1=0xBEEF.
REQ-033 The bench SHALL cover: both requesters read continuously for 4 cycles from reset -> grants alternate 0,1,0,1; responses alternate rsp0/rsp1 one cycle later.
REQ-034 The bench SHALL cover: req0 write adr 1 data 0x1234 and req1 read radr1=1, radr2=3 in the same cycle, with reg1=0x0005 and reg3=0x00AA beforehand -> both ready. With the macro, rsp_data1=0x1234; without it, rsp_data1=0x0005; rsp_data2=0x00AA in both builds.
REQ-035 The bench SHALL cover: req1 valid read held while req0 holds priority in a conflict -> req1_ready=0 that cycle; req1 granted the next cycle with unchanged fields.
